// File: rtl/batalla_pkg.sv
// Shared types and default boat-count limits for the battleship setup and placement logic.
package batalla_pkg;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_SELECT,
    SEL_DONE
  } sel_state_t;

  localparam int unsigned MIN_BARCOS_DEF = 1;
  localparam int unsigned MAX_BARCOS_DEF = 5;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/contador_barcos_updown.sv
// Bounded up/down boat counter; saturates at MIN/MAX, or wraps when SELECTOR_WRAP_EN is defined.
module contador_barcos_updown
  import batalla_pkg::*;
#(
  parameter int unsigned MIN   = MIN_BARCOS_DEF,
  parameter int unsigned MAX   = MAX_BARCOS_DEF,
  parameter int unsigned CNT_W = cnt_width(MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  input  logic             en,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] MinV = CNT_W'(MIN);
  localparam logic [CNT_W-1:0] MaxV = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] OneV = CNT_W'(1);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = MinV;
    end else if (en && inc && !dec) begin
      if (value_q >= MaxV) begin
`ifdef SELECTOR_WRAP_EN
        value_d = MinV;
`else
        value_d = MaxV;
`endif
      end else begin
        value_d = value_q + OneV;
      end
    end else if (en && dec && !inc) begin
      if (value_q <= MinV) begin
`ifdef SELECTOR_WRAP_EN
        value_d = MaxV;
`else
        value_d = MinV;
`endif
      end else begin
        value_d = value_q - OneV;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= MinV;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/selector_barcos_multijugador.sv
// Per-player boat-count selection FSM for the setup phase.
// Define SELECTOR_WRAP_EN to make inc/dec wrap at the limits instead of saturating.
module selector_barcos_multijugador
  import batalla_pkg::*;
#(
  parameter int unsigned NUM_JUGADORES = 2,
  parameter int unsigned MIN_BARCOS    = MIN_BARCOS_DEF,
  parameter int unsigned MAX_BARCOS    = MAX_BARCOS_DEF,
  parameter int unsigned CNT_W         = cnt_width(MAX_BARCOS),
  parameter int unsigned JUG_W         = (NUM_JUGADORES > 1) ? $clog2(NUM_JUGADORES) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             inc,
  input  logic                             dec,
  input  logic                             confirm,
  input  logic                             new_game,
  output logic [CNT_W-1:0]                 result,
  output logic [JUG_W-1:0]                 jugador,
  output logic [NUM_JUGADORES*CNT_W-1:0]   counts,
  output logic                             FSM_next_State,
  output logic                             listo_pulse
);

  localparam logic [JUG_W-1:0] LastJug = JUG_W'(NUM_JUGADORES - 1);
  localparam logic [JUG_W-1:0] OneJug  = JUG_W'(1);

  sel_state_t                       state_q, state_d;
  logic [JUG_W-1:0]                 jug_q, jug_d;
  logic [NUM_JUGADORES*CNT_W-1:0]   counts_q, counts_d;
  logic                             listo_q, listo_d;

  logic active_sel;
  logic last_jug;
  logic cnt_clr;
  logic cnt_en;

  assign active_sel = enable && (state_q == SEL_SELECT);
  assign last_jug   = (jug_q == LastJug);
  // Confirm outranks inc/dec, so the counter is frozen while a confirm is taken.
  assign cnt_en     = active_sel && !confirm;
  assign cnt_clr    = new_game || (active_sel && confirm && !last_jug);

  contador_barcos_updown #(
    .MIN   (MIN_BARCOS),
    .MAX   (MAX_BARCOS),
    .CNT_W (CNT_W)
  ) u_contador (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (inc),
    .dec   (dec),
    .en    (cnt_en),
    .value (result)
  );

  always_comb begin
    state_d  = state_q;
    jug_d    = jug_q;
    counts_d = counts_q;
    if (new_game) begin
      state_d  = SEL_IDLE;
      jug_d    = '0;
      counts_d = '0;
    end else if (enable) begin
      unique case (state_q)
        SEL_IDLE: state_d = SEL_SELECT;
        SEL_SELECT: begin
          if (confirm) begin
            counts_d[jug_q*CNT_W +: CNT_W] = result;
            if (last_jug) begin
              state_d = SEL_DONE;
            end else begin
              jug_d = jug_q + OneJug;
            end
          end
        end
        SEL_DONE: state_d = SEL_DONE;
        default:  state_d = SEL_IDLE;
      endcase
    end
  end

  assign listo_d = (state_d == SEL_DONE) && (state_q != SEL_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEL_IDLE;
      jug_q    <= '0;
      counts_q <= '0;
      listo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      jug_q    <= jug_d;
      counts_q <= counts_d;
      listo_q  <= listo_d;
    end
  end

  assign jugador        = jug_q;
  assign counts         = counts_q;
  assign FSM_next_State = (state_q == SEL_DONE);
  assign listo_pulse    = listo_q;

endmodule
